// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing for the 480x272 parallel RGB panel.
// A pixel-rate divider drives horizontal and vertical counters. Every output
// is registered from the decode of the next-state counters, so the outputs
// always match the counter values held in the registers, with no skew.
module lcd_timing_gen #(
  parameter int PIXEL_DIV       = 3,
  parameter int H_ACTIVE        = 480,
  parameter int H_FP            = 2,
  parameter int H_SYNC          = 41,
  parameter int H_BP            = 2,
  parameter int V_ACTIVE        = 272,
  parameter int V_FP            = 2,
  parameter int V_SYNC          = 10,
  parameter int V_BP            = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        pixel_tick,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A total of 1 would give a zero-width counter, so every counter is at least 1 bit.
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIXEL_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  // Region bounds carry one extra bit so that a bound equal to 2**HW
  // (for example a line that is entirely active) does not truncate to zero.
  localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // Level of hsync/vsync when the pulse is not asserted.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  // Counter state
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q,   h_cnt_d;
  logic [VW-1:0] v_cnt_q,   v_cnt_d;
  logic [15:0]   frame_count_q, frame_count_d;

  // run_q is low for the first edge after reset. That edge loads position
  // (0,0) and pixel 0 then lasts a full PIXEL_DIV clocks.
  logic run_q;

  // Registered outputs and their next-state decode
  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic div_wrap, h_wrap, v_wrap;
  logic h_in_active, v_in_active, h_in_sync, v_in_sync;

  // Next-state counters: the divider steps every clock, h_cnt steps when the
  // divider wraps, v_cnt steps when h_cnt wraps, and frame_count steps when
  // the whole raster wraps back to (0,0).
  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_count_d = frame_count_q;
    div_wrap      = (div_cnt_q == DIV_LAST);
    h_wrap        = (h_cnt_q == H_LAST);
    v_wrap        = (v_cnt_q == V_LAST);
    if (run_q) begin
      if (div_wrap) begin
        div_cnt_d = '0;
        if (h_wrap) begin
          h_cnt_d = '0;
          if (v_wrap) begin
            v_cnt_d       = '0;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
    end
  end

  // Output decode of the next-state counters, registered below so the outputs
  // line up with the counter registers.
  always_comb begin
    h_in_active   = ({1'b0, h_cnt_d} < H_ACT_END);
    v_in_active   = ({1'b0, v_cnt_d} < V_ACT_END);
    h_in_sync     = ({1'b0, h_cnt_d} >= H_SYNC_BEG) && ({1'b0, h_cnt_d} < H_SYNC_END);
    v_in_sync     = ({1'b0, v_cnt_d} >= V_SYNC_BEG) && ({1'b0, v_cnt_d} < V_SYNC_END);
    de_d          = h_in_active && v_in_active;
    x_d           = 9'd0;
    y_d           = 9'd0;
    if (de_d) begin
      x_d = 9'(h_cnt_d);
      y_d = 9'(v_cnt_d);
    end
    hsync_d       = h_in_sync ? ~SYNC_IDLE : SYNC_IDLE;
    vsync_d       = v_in_sync ? ~SYNC_IDLE : SYNC_IDLE;
    pixel_tick_d  = (div_cnt_d == '0);
    line_start_d  = pixel_tick_d && (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_cnt_d == '0);
  end

  // State and output registers. Reset aborts the raster at once and holds
  // the panel outputs at their idle levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_q         <= 1'b0;
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_count_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_count_q <= frame_count_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixel_tick  = pixel_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen. Three instances run side by side:
//   S - small raster (12x7, 2 clocks/pixel) with directed and random resets
//   D - default 480x272 raster, checked over its first few dozen lines
//   T - 1x1 raster at 1 clock/pixel, so frame_count wraps 65535->0 quickly
// Expected outputs come from a position-from-elapsed-time model and are
// queued by the stimulus process; a monitor pops and compares them.
module tb_lcd_timing_gen;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        pt;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } out_t;

  typedef struct packed {
    out_t o;
    logic inRst;
  } exp_t;

  localparam int NCYC = 65600;

  logic clock;
  logic rstS, rstD, rstT;

  logic [8:0]  xS, yS, xD, yD, xT, yT;
  logic        deS, hsS, vsS, ptS, lsS, fsS;
  logic        deD, hsD, vsD, ptD, lsD, fsD;
  logic        deT, hsT, vsT, ptT, lsT, fsT;
  logic [15:0] fcS, fcD, fcT;

  out_t actS, actD, actT;
  assign actS = {xS, yS, deS, hsS, vsS, ptS, lsS, fsS, fcS};
  assign actD = {xD, yD, deD, hsD, vsD, ptD, lsD, fsD, fcD};
  assign actT = {xT, yT, deT, hsT, vsT, ptT, lsT, fsT, fcT};

  exp_t qS[$];
  exp_t qD[$];
  exp_t qT[$];

  int testsRun = 0;
  int testsFailed = 0;

  lcd_timing_gen #(
    .PIXEL_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_LOW(1)
  ) dutS (
    .clock(clock), .reset(rstS), .x(xS), .y(yS), .de(deS), .hsync(hsS),
    .vsync(vsS), .pixel_tick(ptS), .line_start(lsS), .frame_start(fsS),
    .frame_count(fcS)
  );

  lcd_timing_gen dutD (
    .clock(clock), .reset(rstD), .x(xD), .y(yD), .de(deD), .hsync(hsD),
    .vsync(vsD), .pixel_tick(ptD), .line_start(lsD), .frame_start(fsD),
    .frame_count(fcD)
  );

  lcd_timing_gen #(
    .PIXEL_DIV(1), .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_ACTIVE_LOW(1)
  ) dutT (
    .clock(clock), .reset(rstT), .x(xT), .y(yT), .de(deT), .hsync(hsT),
    .vsync(vsT), .pixel_tick(ptT), .line_start(lsT), .frame_start(fsT),
    .frame_count(fcT)
  );

  // Free-running system clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: t is the number of clocks since the first edge after
  // reset was released (negative while in reset). The raster position is
  // just elapsed pixels taken modulo the line and frame lengths.
  function automatic out_t model(input int t, input int pd,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp);
    out_t o;
    int ht, vt, p, h, v;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (t < 0) return o;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p = t / pd;
    h = p % ht;
    v = (p / ht) % vt;
    o.de = (h < ha) && (v < va);
    if (o.de) begin
      o.x = 9'(h);
      o.y = 9'(v);
    end
    o.hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    o.vs = !((v >= va + vfp) && (v < va + vfp + vsw));
    o.pt = ((t % pd) == 0);
    o.ls = o.pt && (h == 0);
    o.fs = o.ls && (v == 0);
    o.fc = 16'((t / (pd * ht * vt)) % 65536);
    return o;
  endfunction

  task automatic checkOutput(input string name, input int cyc, input out_t act, input out_t exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s cycle %0d: got x=%0d y=%0d de=%b hs=%b vs=%b pt=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b pt=%b ls=%b fs=%b fc=%0d",
               name, cyc, act.x, act.y, act.de, act.hs, act.vs, act.pt, act.ls, act.fs, act.fc,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.pt, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Advance one instance's elapsed-time counter for the coming edge and queue
  // the outputs expected after it.
  task automatic applyStimulus(input logic rst, inout int t, output exp_t e,
                               input int pd, input int ha, input int hfp, input int hsw, input int hbp,
                               input int va, input int vfp, input int vsw, input int vbp);
    if (rst) t = -1;
    else     t = (t < 0) ? 0 : t + 1;
    e.o = model(t, pd, ha, hfp, hsw, hbp, va, vfp, vsw, vbp);
    e.inRst = rst;
  endtask

  // Stimulus: reset sequencing for all three instances, one decision per edge.
  initial begin
    int tS, tD, tT, burst;
    exp_t e;
    tS = -1; tD = -1; tT = -1; burst = 0;
    rstS = 1'b1; rstD = 1'b1; rstT = 1'b1;
    applyStimulus(rstS, tS, e, 2, 8, 1, 2, 1, 4, 1, 1, 1); qS.push_back(e);
    applyStimulus(rstD, tD, e, 3, 480, 2, 41, 2, 272, 2, 10, 2); qD.push_back(e);
    applyStimulus(rstT, tT, e, 1, 1, 0, 0, 0, 1, 0, 0, 0); qT.push_back(e);
    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      @(posedge clock);
      #1;
      // Small raster: 5-clock initial reset, a one-clock reset on the edge
      // that would enter line 2 x=5 of the fourth frame, then random bursts.
      if (cyc < 5) begin
        rstS = 1'b1;
      end else if (!rstS && tS >= 0 && tS + 1 == 3 * 168 + 58) begin
        rstS = 1'b1;
      end else if (burst > 0) begin
        rstS = 1'b1;
        burst--;
      end else if (cyc > 1200 && $urandom_range(0, 599) == 0) begin
        rstS = 1'b1;
        burst = $urandom_range(0, 2);
      end else begin
        rstS = 1'b0;
      end
      rstD = (cyc < 3);
      rstT = (cyc < 2);
      applyStimulus(rstS, tS, e, 2, 8, 1, 2, 1, 4, 1, 1, 1); qS.push_back(e);
      applyStimulus(rstD, tD, e, 3, 480, 2, 41, 2, 272, 2, 10, 2); qD.push_back(e);
      applyStimulus(rstT, tT, e, 1, 1, 0, 0, 0, 1, 0, 0, 0); qT.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    checkValue("scoreboard S drained", qS.size(), 0);
    checkValue("scoreboard D drained", qD.size(), 0);
    checkValue("scoreboard T drained", qT.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Monitor: compares every cycle's outputs against the queued expectation
  // and measures frame_start spacing (small) and line_start spacing (default).
  initial begin
    int mc, lastFsS, lastLsD;
    bit validS, validD;
    exp_t e;
    mc = 0; lastFsS = 0; lastLsD = 0; validS = 0; validD = 0;
    forever begin
      @(negedge clock);
      mc++;
      if (qS.size() > 0) begin
        e = qS.pop_front();
        checkOutput("small raster", mc, actS, e.o);
        if (e.inRst) validS = 0;
        else if (actS.fs === 1'b1) begin
          if (validS) checkValue("small frame_start spacing", mc - lastFsS, 168);
          lastFsS = mc;
          validS = 1;
        end
      end
      if (qD.size() > 0) begin
        e = qD.pop_front();
        checkOutput("default raster", mc, actD, e.o);
        if (e.inRst) validD = 0;
        else if (actD.ls === 1'b1) begin
          if (validD) checkValue("default line_start spacing", mc - lastLsD, 1575);
          lastLsD = mc;
          validD = 1;
        end
      end
      if (qT.size() > 0) begin
        e = qT.pop_front();
        checkOutput("tiny raster frame_count", mc, actT, e.o);
      end
    end
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Raster timing generator for the 480×272 parallel RGB LCD. It divides the system clock down to the pixel rate, walks the horizontal and vertical counters, and drives the panel HSYNC, VSYNC and DE. It supplies the `x`/`y` coordinates consumed by the per-pixel colour logic in `hackathon_top`, plus frame and line strobes that animation logic can use in place of a free-running `strobe_gen`.

## Interface

**Parameters**
- `PIXEL_DIV`, default 3: system clocks per pixel (27 MHz → 9 MHz); legal range is ≥1.
- `H_ACTIVE`, default 480: visible pixels per line.
- `H_FP`, default 2: horizontal front porch, in pixels.
- `H_SYNC`, default 41: HSYNC width, in pixels.
- `H_BP`, default 2: horizontal back porch, in pixels.
- `V_ACTIVE`, default 272: visible lines per frame.
- `V_FP`, default 2: vertical front porch, in lines.
- `V_SYNC`, default 10: VSYNC width, in lines.
- `V_BP`, default 2: vertical back porch, in lines.
- `SYNC_ACTIVE_LOW`, default 1: when 1, `hsync`/`vsync` are driven low while asserted.

**Ports**
- `clock`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `x`, output, 9: active column, 0..H_ACTIVE-1. Reads 0 whenever `de`=0.
- `y`, output, 9: active row, 0..V_ACTIVE-1. Reads 0 whenever `de`=0.
- `de`, output, 1: data enable; high inside the active area.
- `hsync`, output, 1: horizontal sync, polarity set by `SYNC_ACTIVE_LOW`.
- `vsync`, output, 1: vertical sync, polarity set by `SYNC_ACTIVE_LOW`.
- `pixel_tick`, output, 1: high on the first clock of every pixel period.
- `line_start`, output, 1: one-clock pulse on the first clock of pixel h=0 of every line, including blanking lines.
- `frame_start`, output, 1: one-clock pulse on the first clock of pixel (0,0).
- `frame_count`, output, 16: count of completed frames; wraps at 65535→0.

## Operation

**Totals**
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; default 525.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; default 286.
- Internal counter widths are ceil(log2) of each total. Defaults: `h_cnt` 10 bits, `v_cnt` 9 bits.

**Counters**
- `div_cnt` runs 0..PIXEL_DIV-1 and wraps.
- `h_cnt` advances only on the edge where `div_cnt` wraps. It wraps at H_TOTAL-1 → 0.
- `v_cnt` advances only on the edge where `h_cnt` wraps. It wraps at V_TOTAL-1 → 0.

**Region order**
- Each line is ordered active, front porch, sync, back porch.
- Each frame is ordered the same way, counted in lines.

**Output decode**
All outputs are registered and always equal the decode of the current counter values, with zero skew. Implement this by decoding the next-state counters.
- `de` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- `hsync` is asserted when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line.
- `vsync` is asserted when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. It therefore changes only at h_cnt=0.
- `x` = h_cnt[8:0] and `y` = v_cnt[8:0] while `de`=1; both are 0 otherwise.
- `pixel_tick` = (div_cnt==0). With PIXEL_DIV=1 it is constant 1 outside reset.
- `line_start` = pixel_tick && h_cnt==0.
- `frame_start` = line_start && v_cnt==0.

**frame_count**
- Increments on the edge where (h_cnt,v_cnt) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0). Its new value is therefore visible on the same clock as `frame_start`.

**Reset**
- All counters and `frame_count` go to 0.
- While `reset` is high, outputs are forced: `de`=0, `x`=0, `y`=0, `pixel_tick`=0, `line_start`=0, `frame_start`=0.
- `hsync` and `vsync` are held inactive during reset: 1 when SYNC_ACTIVE_LOW=1, 0 otherwise.
- Reset asserted mid-frame aborts the frame immediately; no partial-line completion.

## Timing

- On the first clock edge with `reset` low, outputs load decode(0,0). On the following cycle `de`=1, x=0, y=0, and `pixel_tick`, `line_start` and `frame_start` are all 1.
- Each pixel lasts exactly PIXEL_DIV clocks. `x` changes only on clocks where `pixel_tick`=1.
- Line period is H_TOTAL×PIXEL_DIV clocks; default 1575.
- Frame period is that line period × V_TOTAL; default 450 450 clocks, about 59.9 Hz at 27 MHz.
- The last active pixel (479,271) is followed, after the blanking clocks, by `frame_start` exactly one pixel period after h_cnt=H_TOTAL-1 on line V_TOTAL-1.
- There is no input handshake. Downstream logic samples colour combinationally against `x`/`y`/`de`.

## Test plan

Small-parameter bench settings: PIXEL_DIV=2, H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=12), V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7).

1. **Reset release:** hold reset 5 clocks, then release. During reset, de=0 and hsync=vsync=1. On the first cycle after the release edge: de=1, x=0, y=0, pixel_tick=1, line_start=1, frame_start=1, frame_count=0.
2. **Horizontal sequencing:** over one line (24 clocks):
   - x steps 0..7, each value held 2 clocks.
   - de is high for 16 clocks.
   - hsync is low for exactly 4 clocks, starting 18 clocks after line_start.
3. **Vertical sequencing:**
   - de is never high on lines 4..6.
   - vsync is low for exactly 24 clocks, starting at line_start of line 5.
   - line_start pulses 7 times per frame.
4. **Frame wrap:**
   - frame_start pulses are spaced exactly 168 clocks apart.
   - frame_count reads 1, 2, 3 at successive frame_start pulses.
   - Force frame_count to 65535 and check it wraps to 0.
5. **Mid-frame reset:** assert reset at line 2, x=5 for 1 clock. Outputs go to reset values on the next edge. After release, the raster restarts at (0,0) with frame_count=0.
6. **Default parameters:** line period is 1575 clocks, frame period is 450 450 clocks. Confirm de covers exactly 480×272 pixel periods per frame, and sample (x,y)=(479,271) at its last de-high pixel.
